// File: rtl/grid_scanner_if.sv
// Cell record stream between the grid scanner and the renderer.
// The master drives the record; the slave returns out_ready.
interface grid_scanner_if #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [X_BITS-1:0] cell_x;
  logic [Y_BITS-1:0] cell_y;
  logic [2:0]        cell_code;
  logic              out_last;

  modport master (
    output out_valid,
    output cell_x,
    output cell_y,
    output cell_code,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  cell_x,
    input  cell_y,
    input  cell_code,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/grid_scanner.sv
// Frame scanner: snapshots the player grid vectors, streams every
// cell row-major and reports per-frame collision flags.
module grid_scanner #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [GRID_W-1:0] wall_p1_x,
  input  logic [GRID_W-1:0] wall_p2_x,
  input  logic [GRID_W-1:0] LOC_p1_x,
  input  logic [GRID_W-1:0] LOC_p2_x,
  input  logic [GRID_H-1:0] wall_p1_y,
  input  logic [GRID_H-1:0] wall_p2_y,
  input  logic [GRID_H-1:0] LOC_p1_y,
  input  logic [GRID_H-1:0] LOC_p2_y,
  grid_scanner_if.master    strm,
  output logic              busy,
  output logic              frame_done,
  output logic              hit_p1,
  output logic              hit_p2
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);

  logic [1:0]        r_state;
  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;

  logic [GRID_W-1:0] r_w1x;
  logic [GRID_W-1:0] r_w2x;
  logic [GRID_W-1:0] r_l1x;
  logic [GRID_W-1:0] r_l2x;
  logic [GRID_H-1:0] r_w1y;
  logic [GRID_H-1:0] r_w2y;
  logic [GRID_H-1:0] r_l1y;
  logic [GRID_H-1:0] r_l2y;

  logic r_acc1;
  logic r_acc2;
  logic r_hit1;
  logic r_hit2;

  logic       w_scan;
  logic       w_xfer;
  logic       w_last;
  logic       w_xend;
  logic       w_in_w1;
  logic       w_in_w2;
  logic       w_in_p1;
  logic       w_in_p2;
  logic       w_c1;
  logic       w_c2;
  logic [2:0] w_code;

  assign w_scan = (r_state == S_SCAN);
  assign w_xfer = w_scan & strm.out_ready;
  assign w_xend = (r_x == X_MAX);
  assign w_last = w_scan & w_xend & (r_y == Y_MAX);

  // Membership is always taken on the snapshot, never the live inputs.
  assign w_in_w1 = r_w1x[r_x] & r_w1y[r_y];
  assign w_in_w2 = r_w2x[r_x] & r_w2y[r_y];
  assign w_in_p1 = r_l1x[r_x] & r_l1y[r_y];
  assign w_in_p2 = r_l2x[r_x] & r_l2y[r_y];

  assign w_c1 = w_in_p1 & (w_in_w1 | w_in_w2 | w_in_p2);
  assign w_c2 = w_in_p2 & (w_in_w1 | w_in_w2 | w_in_p1);

  // Cell content decode: players over walls, p1 over p2.
  always_comb begin
    w_code = 3'd0;
    if (w_scan) begin
      priority case (1'b1)
        w_in_p1: w_code = 3'd3;
        w_in_p2: w_code = 3'd4;
        w_in_w1: w_code = 3'd1;
        w_in_w2: w_code = 3'd2;
        default: w_code = 3'd0;
      endcase
    end
  end

  // Frame sequencing: IDLE -> SCAN -> DONE -> IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_state <= S_SCAN;
        S_SCAN: if (w_xfer && w_last) r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture all eight vectors when a scan is launched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_w1x <= '0;
      r_w2x <= '0;
      r_l1x <= '0;
      r_l2x <= '0;
      r_w1y <= '0;
      r_w2y <= '0;
      r_l1y <= '0;
      r_l2y <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_w1x <= wall_p1_x;
      r_w2x <= wall_p2_x;
      r_l1x <= LOC_p1_x;
      r_l2x <= LOC_p2_x;
      r_w1y <= wall_p1_y;
      r_w2y <= wall_p2_y;
      r_l1y <= LOC_p1_y;
      r_l2y <= LOC_p2_y;
    end
  end

  // Row-major cell counters; held on stall and on the final record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_xfer && !w_last) begin
      if (w_xend) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Collision accumulators fold in each transferred record.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc1 <= 1'b0;
      r_acc2 <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_acc1 <= 1'b0;
      r_acc2 <= 1'b0;
    end else if (w_xfer) begin
      r_acc1 <= r_acc1 | w_c1;
      r_acc2 <= r_acc2 | w_c2;
    end
  end

  // Publish the frame's flags as DONE is entered so they are valid with frame_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
    end else if (w_xfer && w_last) begin
      r_hit1 <= r_acc1 | w_c1;
      r_hit2 <= r_acc2 | w_c2;
    end
  end

  assign strm.out_valid = w_scan;
  assign strm.cell_x    = r_x;
  assign strm.cell_y    = r_y;
  assign strm.cell_code = w_code;
  assign strm.out_last  = w_last;

  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign hit_p1     = r_hit1;
  assign hit_p2     = r_hit2;

endmodule
